// File: rtl/packet_framer_pkg.sv
// Shared definitions for the packet framer.
//   state_e     : framer FSM states
//   GAP_CYCLES  : idle cycles enforced after every eop
//   len_clamp() : maps a requested length onto the legal range 1..2**awidth
package packet_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Covers the sorter's busy rise latency so the next launch never
    // overlaps its output phase.
    localparam int GAP_CYCLES = 2;

    function automatic int len_clamp(input int len, input int awidth);
        int max_len;
        max_len = 1 << awidth;
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/packet_framer_if.sv
// Bus between the framer control logic and its word FIFO.
//   wr/data       : push request and word (master -> FIFO)
//   rd            : pop request, FIFO is show-ahead so q is the head word
//   q/count       : head word and occupancy (FAWIDTH+1 bits)
//   full/empty    : status; full is registered and forced high in reset
// Handshake: a push happens on a clock edge where wr && !full, a pop on
// an edge where rd && !empty; both may happen on the same edge.
interface packet_framer_if #(
    parameter int DWIDTH  = 8,
    parameter int FAWIDTH = 4
);
    logic               wr;
    logic               rd;
    logic [DWIDTH-1:0]  data;
    logic [DWIDTH-1:0]  q;
    logic [FAWIDTH:0]   count;
    logic               full;
    logic               empty;

    modport master (
        output wr, rd, data,
        input  q, count, full, empty
    );

    modport slave (
        input  wr, rd, data,
        output q, count, full, empty
    );
endinterface

// File: rtl/packet_framer_fifo.sv
// framer_fifo: single-clock show-ahead FIFO, depth 2**FAWIDTH.
//   clk_i  : clock, rising edge
//   srst_i : synchronous active-low reset, discards contents
//   bus    : packet_framer_if slave (wr, rd, data, q, count, full, empty)
module framer_fifo #(
    parameter int DWIDTH  = 8,
    parameter int FAWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    packet_framer_if.slave    bus
);
    localparam int DEPTH = 2 ** FAWIDTH;

    logic [DWIDTH-1:0]  mem_q [DEPTH];
    logic [FAWIDTH-1:0] wr_ptr_q;
    logic [FAWIDTH-1:0] rd_ptr_q;
    logic [FAWIDTH:0]   count_q;
    logic [FAWIDTH:0]   count_d;
    logic               full_q;
    logic               do_wr;
    logic               do_rd;

    assign do_wr = bus.wr && !full_q;
    assign do_rd = bus.rd && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (FAWIDTH+1)'(1);
            2'b01:   count_d = count_q - (FAWIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // full is held high during reset so the upstream sees ready low, and
    // is computed from the next count so ready stays a pure register.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + FAWIDTH'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + FAWIDTH'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == (FAWIDTH+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end

    assign bus.q     = mem_q[rd_ptr_q];
    assign bus.count = count_q;
    assign bus.full  = full_q;
    assign bus.empty = (count_q == '0);

endmodule

// File: rtl/packet_framer.sv
// packet_framer: buffers an unframed valid/ready word stream and emits
// contiguous packets of a programmable length with sop/eop/val framing,
// launching only while the downstream sorter is not busy.
//   clk_i, srst_i        : clock, synchronous active-low reset
//   data_i/val_i/ready_o : input stream, transfer on val_i && ready_o
//   len_i                : packet length, clamped to 1..2**AWIDTH at launch
//   busy_i               : sorter busy, only looked at in IDLE
//   data_o/sop_o/eop_o/val_o : registered packet output
module packet_framer
    import packet_framer_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 3,
    parameter int FAWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              val_i,
    output logic              ready_o,
    input  logic [AWIDTH:0]   len_i,
    input  logic              busy_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o
);
    packet_framer_if #(.DWIDTH(DWIDTH), .FAWIDTH(FAWIDTH)) fifo_bus ();

    framer_fifo #(.DWIDTH(DWIDTH), .FAWIDTH(FAWIDTH)) u_fifo (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .bus    (fifo_bus.slave)
    );

    state_e            state_q, state_d;
    logic [AWIDTH:0]   rem_q, rem_d;
    logic [1:0]        gap_q, gap_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              val_q, val_d;
    logic              rd;
    logic [AWIDTH:0]   len_eff;

    assign len_eff = (AWIDTH+1)'(len_clamp(int'(len_i), AWIDTH));

    assign ready_o       = !fifo_bus.full;
    assign fifo_bus.wr   = val_i && ready_o;
    assign fifo_bus.data = data_i;
    assign fifo_bus.rd   = rd;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        data_d  = data_q;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        val_d   = 1'b0;
        rd      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Launch only with the whole packet buffered so it can
                // go out without bubbles.
                if (!fifo_bus.empty && !busy_i &&
                    (fifo_bus.count >= (FAWIDTH+1)'(len_eff))) begin
                    rd     = 1'b1;
                    data_d = fifo_bus.q;
                    sop_d  = 1'b1;
                    val_d  = 1'b1;
                    rem_d  = len_eff - (AWIDTH+1)'(1);
                    if (len_eff == (AWIDTH+1)'(1)) begin
                        eop_d   = 1'b1;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                rd     = 1'b1;
                data_d = fifo_bus.q;
                val_d  = 1'b1;
                rem_d  = rem_q - (AWIDTH+1)'(1);
                if (rem_q == (AWIDTH+1)'(1)) begin
                    eop_d   = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 2'd1;
                if (gap_q == 2'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            val_q   <= val_d;
        end
    end

    assign data_o = data_q;
    assign sop_o  = sop_q;
    assign eop_o  = eop_q;
    assign val_o  = val_q;

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer: a vector table of length/word-count
// cases plus hand-written reset, busy, full/wrap and mid-packet-reset runs.
module tb_packet_framer;
    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int FAW = 4;

    logic          clk = 1'b0;
    logic          srst_i;
    logic [DW-1:0] data_i;
    logic          val_i;
    logic          ready_o;
    logic [AW:0]   len_i;
    logic          busy_i;
    logic [DW-1:0] data_o;
    logic          sop_o;
    logic          eop_o;
    logic          val_o;

    always #5 clk = ~clk;

    packet_framer #(.DWIDTH(DW), .AWIDTH(AW), .FAWIDTH(FAW)) dut (
        .clk_i   (clk),
        .srst_i  (srst_i),
        .data_i  (data_i),
        .val_i   (val_i),
        .ready_o (ready_o),
        .len_i   (len_i),
        .busy_i  (busy_i),
        .data_o  (data_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .val_o   (val_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        int            cyc;
    } obs_t;

    obs_t          mon_q[$];
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int last_eop_cyc = -1;
    int last_wr_cyc = 0;

    always @(negedge clk) begin
        if (val_o === 1'b1) begin
            obs_t o;
            o.data = data_o;
            o.sop  = sop_o;
            o.eop  = eop_o;
            o.cyc  = cyc;
            mon_q.push_back(o);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        int t;
        t = 0;
        data_i = d;
        val_i  = 1'b1;
        while (ready_o !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            fail_msg("push_timeout", t, 0);
            val_i = 1'b0;
        end else begin
            tick();
            val_i = 1'b0;
            exp_q.push_back(d);
            last_wr_cyc = cyc;
        end
    endtask

    task automatic check_packet(input int n, output int first_cyc);
        int   t;
        int   prev;
        obs_t o;
        logic [DW-1:0] e;
        t = 0;
        first_cyc = -1;
        prev = 0;
        while (mon_q.size() < n && t < 400) begin
            tick();
            t++;
        end
        if (mon_q.size() < n) begin
            fail_msg("pkt_timeout", mon_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                o = mon_q.pop_front();
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk("pkt_data", o.data, e);
                chk("pkt_sop", o.sop, (i == 0));
                chk("pkt_eop", o.eop, (i == n - 1));
                if (i == 0) begin
                    first_cyc = o.cyc;
                    if (last_eop_cyc >= 0) begin
                        chk("pkt_gap", (o.cyc - last_eop_cyc >= 3), 1);
                    end
                end else begin
                    chk("pkt_contig", o.cyc, prev + 1);
                end
                prev = o.cyc;
            end
            last_eop_cyc = prev;
        end
    endtask

    typedef struct {
        logic [AW:0] len;
        int          nwords;
        int          pkt_len;
        int          n_pkts;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            first;
        int            rel_cyc;
        int            acc;
        int            n;
        logic [DW-1:0] nxt;
        logic [DW-1:0] fw [20];
        obs_t          o;

        vecs[0] = '{len: 4'd4,  nwords: 4,  pkt_len: 4, n_pkts: 1};
        vecs[1] = '{len: 4'd0,  nwords: 1,  pkt_len: 1, n_pkts: 1};
        vecs[2] = '{len: 4'd12, nwords: 8,  pkt_len: 8, n_pkts: 1};
        vecs[3] = '{len: 4'd1,  nwords: 3,  pkt_len: 1, n_pkts: 3};
        vecs[4] = '{len: 4'd8,  nwords: 16, pkt_len: 8, n_pkts: 2};
        vecs[5] = '{len: 4'd2,  nwords: 6,  pkt_len: 2, n_pkts: 3};
        vecs[6] = '{len: 4'd5,  nwords: 5,  pkt_len: 5, n_pkts: 1};

        // Reset held while the upstream is pushing.
        srst_i = 1'b0;
        val_i  = 1'b1;
        data_i = 8'hAA;
        len_i  = 4'd1;
        busy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", ready_o, 0);
            chk("rst_val", val_o, 0);
            chk("rst_sop", sop_o, 0);
            chk("rst_eop", eop_o, 0);
            chk("rst_data", data_o, 0);
        end
        srst_i = 1'b1;
        val_i  = 1'b0;
        tick();
        chk("ready_after_reset", ready_o, 1);
        repeat (5) tick();
        chk("no_word_stored_in_reset", mon_q.size(), 0);

        // Table of length / word-count cases.
        nxt = 8'h11;
        for (int v = 0; v < 7; v++) begin
            len_i = vecs[v].len;
            for (int w = 0; w < vecs[v].nwords; w++) begin
                push_word(nxt);
                nxt = nxt + 8'h11;
            end
            for (int p = 0; p < vecs[v].n_pkts; p++) begin
                check_packet(vecs[v].pkt_len, first);
                if (vecs[v].n_pkts == 1) begin
                    chk("launch_latency", first, last_wr_cyc + 1);
                end
            end
            repeat (4) tick();
            chk("stray_output", mon_q.size(), 0);
        end

        // Busy hold-off.
        busy_i = 1'b1;
        len_i  = 4'd2;
        push_word(8'h5A);
        push_word(8'hA5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_hold_val", val_o, 0);
        end
        busy_i  = 1'b0;
        rel_cyc = cyc;
        check_packet(2, first);
        chk("busy_release_launch", first, rel_cyc + 1);
        repeat (4) tick();

        // FIFO full and pointer wrap.
        for (int i = 0; i < 20; i++) fw[i] = 8'(8'h60 + i);
        busy_i = 1'b1;
        len_i  = 4'd8;
        acc    = 0;
        for (int t = 0; t < 60 && acc < 16; t++) begin
            data_i = fw[acc];
            val_i  = 1'b1;
            if (ready_o === 1'b1) begin
                tick();
                exp_q.push_back(fw[acc]);
                acc++;
            end else begin
                tick();
            end
        end
        chk("full_accepted", acc, 16);
        chk("full_ready_low", ready_o, 0);
        data_i = fw[16];
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_ready_held", ready_o, 0);
        end
        val_i  = 1'b0;
        busy_i = 1'b0;
        tick();
        tick();
        len_i = 4'd1;   // must be ignored by the packet in flight
        tick();
        tick();
        len_i = 4'd8;
        for (int i = 16; i < 20; i++) push_word(fw[i]);
        check_packet(8, first);
        check_packet(8, first);
        len_i = 4'd4;
        check_packet(4, first);
        repeat (4) tick();
        chk("wrap_stray_output", mon_q.size(), 0);

        // Reset during word 3 of an 8-word packet.
        busy_i = 1'b1;
        len_i  = 4'd8;
        for (int i = 0; i < 8; i++) push_word(8'(8'hC0 + i));
        busy_i = 1'b0;
        n = 0;
        for (int t = 0; t < 50 && n < 3; t++) begin
            tick();
            if (val_o === 1'b1) n++;
        end
        if (n < 3) fail_msg("midrst_timeout", n, 3);
        srst_i = 1'b0;
        tick();
        chk("midrst_val", val_o, 0);
        chk("midrst_sop", sop_o, 0);
        chk("midrst_eop", eop_o, 0);
        chk("midrst_data", data_o, 0);
        chk("midrst_ready", ready_o, 0);
        chk("midrst_words_seen", mon_q.size(), 3);
        for (int i = 0; i < 3 && mon_q.size() > 0; i++) begin
            o = mon_q.pop_front();
            chk("midrst_word_data", o.data, 8'(8'hC0 + i));
            chk("midrst_word_sop", o.sop, (i == 0));
            chk("midrst_word_eop", o.eop, 0);
        end
        mon_q.delete();
        exp_q.delete();
        last_eop_cyc = -1;
        srst_i = 1'b1;
        len_i  = 4'd1;
        repeat (6) tick();
        chk("fifo_empty_after_reset", mon_q.size(), 0);
        len_i = 4'd4;
        for (int i = 0; i < 4; i++) push_word(8'(8'hE0 + i));
        check_packet(4, first);
        chk("post_reset_latency", first, last_wr_cyc + 1);
        repeat (4) tick();
        chk("final_stray_output", mon_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_framer.md
# packet_framer

Upstream stage of the sorting block. It accepts an unframed word stream with valid/ready flow control, buffers it in an internal FIFO and emits packets of a programmable length with sop/eop/val framing. A packet is launched only while the downstream sorter reports not busy, and is always sent back-to-back with one word per clock. This satisfies the sorter's requirement that a packet arrives contiguously and never overlaps its output phase.

## Interface
- `DWIDTH`, 8: data word width.
- `AWIDTH`, 3: sorter address width; maximum packet length is `2**AWIDTH`.
- `FAWIDTH`, 4: FIFO address width; depth is `2**FAWIDTH`. `FAWIDTH >= AWIDTH` is required.

Ports:
- `clk_i`  in  1  single clock; all logic is on its rising edge.
- `srst_i`  in  1  synchronous reset, active-low; reset is applied while `srst_i == 0`.
- `data_i`  in  `DWIDTH`  input word.
- `val_i`  in  1  `data_i` valid.
- `ready_o`  out  1  FIFO can accept a word. A transfer occurs when `val_i && ready_o`.
- `len_i`  in  `AWIDTH+1`  requested packet length, sampled at packet launch.
- `busy_i`  in  1  sorter busy; connects to the sorter's `busy_o`.
- `data_o`  out  `DWIDTH`  packet word.
- `sop_o`  out  1  first word of packet.
- `eop_o`  out  1  last word of packet.
- `val_o`  out  1  `data_o`/`sop_o`/`eop_o` valid.

## Operation
- **FIFO**
  - A write occurs on `val_i && ready_o`.
  - `ready_o` is registered and equals `!full`.
  - Occupancy count is `FAWIDTH+1` bits wide.
  - Pointers wrap modulo `2**FAWIDTH`.
- **Effective length `len_eff`**
  - `len_i == 0` gives 1.
  - `len_i > 2**AWIDTH` gives `2**AWIDTH`.
  - Any other value is used as is.
  - `len_eff` is latched at launch; changes to `len_i` during a packet are ignored.
- **FSM states:** IDLE, SEND, GAP.
  - **IDLE → SEND** when `count >= len_eff && !busy_i`. On that clock edge:
    - word 0 is loaded to the outputs with `sop_o = 1` and `val_o = 1`;
    - `eop_o = 1` as well if `len_eff == 1`;
    - the remaining-word counter is loaded with `len_eff - 1`.
    - If `len_eff == 1`, the FSM goes directly to GAP.
  - **SEND:** one word per cycle, with `val_o = 1` and `sop_o = 0`. `eop_o = 1` on the final word, then go to GAP.
  - **GAP:** outputs are idle for exactly 2 cycles, which covers the sorter's busy rise latency. Then go to IDLE.
  - **Outside a launch or SEND word,** `val_o`, `sop_o` and `eop_o` are 0 and `data_o` holds its last value.
- **Flow control**
  - `busy_i` is ignored during SEND and GAP. A launched packet always completes.
  - Simultaneous read and write in one cycle is allowed. The count is unchanged and both pointers advance.
- **Full FIFO:** `val_i` is ignored while `ready_o = 0`. No data is lost or overwritten.
- **Reset**
  - All state clears and FIFO contents are discarded.
  - Outputs while `srst_i == 0`: `ready_o = 0`, `val_o = 0`, `sop_o = 0`, `eop_o = 0`, `data_o = 0`. State is IDLE.
  - `ready_o` rises on the first cycle after reset release.
  - A reset mid-packet truncates the packet with no `eop_o`. The sorter is reset by the same reset.

## Timing
- All outputs are registered.
- **Minimum latency:** a word accepted in cycle c is counted in c+1. With `len_eff = 1` and `busy_i = 0`, it appears on `data_o` with sop/eop in cycle c+2.
- **Packet duration:** `len_eff` consecutive cycles of `val_o`, with no bubbles.
- **Packet spacing:** at least 2 idle cycles after eop, plus any cycles where `busy_i = 1`.

## Structure
- **Package `packet_framer_pkg`:**
  - FSM state enum;
  - the GAP length constant (2);
  - the `len_eff` clamp function, parameterised by `AWIDTH`.
- **Sub-module `framer_fifo`:**
  - single-clock show-ahead FIFO, parameters `DWIDTH` and `FAWIDTH`;
  - ports: `wr`, `rd`, `data`, `q`, `count`, `full`, `empty`.
- **Top level:** FSM, length latch, remaining-word counter and output registers.

## Test plan
- **Reset:** hold `srst_i = 0` for 3 cycles while driving `val_i = 1`. Expect all outputs 0 and no words stored. After release, expect `ready_o = 1` on the first cycle.
- **Basic packet:** `len_i = 4`, push 0x11, 0x22, 0x33, 0x44, `busy_i = 0`. Expect `val_o` for 4 consecutive cycles carrying 0x11..0x44, sop on 0x11, eop on 0x44, and first output 2 cycles after the 4th write.
- **Busy hold-off:** `len_i = 2` with 2 words buffered and `busy_i = 1` for 10 cycles. Expect no `val_o` until `busy_i` falls, then a launch on the cycle after.
- **Length edges:**
  - `len_i = 0` with 1 word pushed: expect a single word with `sop_o = eop_o = 1`.
  - `len_i = 12` with `AWIDTH = 3`: expect 8-word packets.
  - Back-to-back packets are separated by at least 2 idle cycles.
- **FIFO full / wrap:** push 20 words with `busy_i = 1`. Expect `ready_o = 0` after 16 accepted words, and words 17–20 held upstream. Release busy with `len_i = 8`, drain 2 packets. Expect data in order across the pointer wrap.
- **Mid-packet reset:** assert reset during word 3 of an 8-word packet. Expect outputs 0 next cycle, FIFO empty, and a clean packet on new data after release.
